// File: rtl/serial_shift_tx_if.sv
// serial_shift_tx_if: load handshake and serial output bundle of the serial transmitter
interface serial_shift_tx_if #(parameter int WIDTH = 4);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             msb_first;
  logic             shift_en;
  logic             sout;
  logic             sout_valid;
  logic             last;
  logic             busy;
  modport master (
    output load_valid, load_data, msb_first, shift_en,
    input  load_ready, sout, sout_valid, last, busy
  );
  modport slave (
    input  load_valid, load_data, msb_first, shift_en,
    output load_ready, sout, sout_valid, last, busy
  );
endinterface

// File: rtl/serial_shift_tx.sv
// serial_shift_tx: parallel-in/serial-out transmitter with valid/ready load and per-word bit order
module serial_shift_tx #(parameter int WIDTH = 4) (
  input logic clk,
  input logic rst_n,
  serial_shift_tx_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             shifting, last, done, load_fire, step;
  always_comb begin
    shifting  = state_q == SHIFT;
    last      = shifting && (cnt_q == CW'(WIDTH - 1));
    done      = last && bus.shift_en;
    load_fire = bus.load_valid && (!shifting || done);
    step      = shifting && bus.shift_en && !last;
    state_d   = load_fire ? SHIFT : done ? IDLE : state_q;
    shreg_d   = load_fire ? bus.load_data : step ? (dir_q ? shreg_q << 1 : shreg_q >> 1) : shreg_q;
    cnt_d     = load_fire ? '0 : step ? cnt_q + 1'b1 : cnt_q;
    dir_d     = load_fire ? bus.msb_first : dir_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end
  assign bus.load_ready = !shifting || done;
  assign bus.sout       = shifting && (dir_q ? shreg_q[WIDTH-1] : shreg_q[0]);
  assign bus.sout_valid = shifting;
  assign bus.busy       = shifting;
  assign bus.last       = last;
endmodule

// File: doc/serial_shift_tx.md
Name: serial_shift_tx

Overview:
- Parallel-in/serial-out transmitter.
- Takes a WIDTH-bit word via a valid/ready load handshake and emits it one bit per accepted shift step.
- Order is LSB-first or MSB-first, selected per word.
- Drives the serial-in bit (il/ir) of downstream shifter/deserializer stages; it is the source end of our serial shift path.

Parameters:
WIDTH, 4, word width in bits; legal range WIDTH >= 2.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous reset, active low
load_valid  input  1  load_data/msb_first valid
load_ready  output  1  transmitter can accept a word this cycle
load_data  input  WIDTH  word to serialize
msb_first  input  1  1 = MSB first, 0 = LSB first; sampled with the word
shift_en  input  1  sink consumes current sout bit this cycle
sout  output  1  current serial bit
sout_valid  output  1  sout holds a valid bit
last  output  1  sout is the final bit of the word
busy  output  1  word in flight (same as sout_valid)

Behaviour:
- Single clock domain.
- Reset: rst_n low at a clock edge forces the following, regardless of state or inputs:
  - state IDLE, shreg=0, cnt=0, dir=0
  - outputs: sout=0, sout_valid=0, last=0, busy=0, load_ready=1
  - load_valid is ignored while rst_n=0
- Reset mid-word discards the word; no partial bits are emitted afterwards.
- FSM states: IDLE, SHIFT.
- IDLE:
  - load_ready=1, sout_valid=0, sout=0.
  - On load_valid=1: shreg<=load_data, dir<=msb_first, cnt<=0, next SHIFT.
- SHIFT:
  - sout = dir ? shreg[WIDTH-1] : shreg[0].
  - sout_valid=1, busy=1, last=(cnt==WIDTH-1).
- In SHIFT, shift_en=1 with last=0:
  - dir=0: shreg<=shreg>>1 with MSB filled 0.
  - dir=1: shreg<=shreg<<1 with LSB filled 0.
  - cnt<=cnt+1.
- In SHIFT, shift_en=0: all state holds and sout is stable (stall of any length).
- In SHIFT, shift_en=1 with last=1 (final bit consumed):
  - load_valid=1: new word loaded exactly as from IDLE; stay SHIFT; zero bubble.
  - load_valid=0: next IDLE.
- load_ready = (state==IDLE) | (last & shift_en). This is combinational from state and shift_en; no dependency on load_valid.
- load_valid=1 while load_ready=0 has no effect; the word is not captured and need not be held by the sender.
- Latency and throughput:
  - First bit appears on sout the cycle after the load handshake.
  - A word occupies exactly WIDTH shift_en-qualified cycles.
  - Sustained throughput is 1 bit/cycle with shift_en tied high.
- msb_first and load_data are sampled only at handshake; later changes do not affect the word in flight.
- The counter is $clog2(WIDTH) bits wide and never passes WIDTH-1.
- All outputs other than load_ready are driven from registered state only (no input-to-output combinational path).

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with load_valid=1 -> sout=0, sout_valid=0, last=0, busy=0, load_ready=1, nothing loaded.
- LSB-first, WIDTH=4: load 4'b1011, msb_first=0, shift_en=1 -> sout 1,1,0,1 on 4 consecutive cycles; last high on 4th only; then IDLE, load_ready=1.
- MSB-first: load 4'b1011, msb_first=1 -> sout 1,0,1,1; sout_valid high exactly 4 cycles.
- Stall: load 4'b0110 LSB-first, shift_en pattern 1,0,0,1,1,1 -> sout 0,1,1,1,1,0; state and bits hold while shift_en=0.
- Back-to-back and ignored load:
  - 4'b1100 (LSB) then 4'b0011 (MSB), load_valid held high, shift_en=1 -> 8 contiguous valid bits 0,0,1,1,0,0,1,1; no idle cycle.
  - A load_valid pulse with data 4'b1111 mid-word is ignored.
- Reset mid-operation: rst_n=0 after 2nd bit of 4'b1010 -> next cycle IDLE, sout_valid=0; a new load of 4'b0001 LSB-first emits 1,0,0,0 cleanly.
